smi_frame_arbiter_x2: RTL and testbench

Merges two SMI frame streams onto one SMI output with frame-atomic round-robin arbitration. It is the converging counterpart of the two-way frame steering block, so request and response paths that were split by message type can be rejoined before a shared link. Each frame is forwarded unbroken, and frames from the two inputs never interleave. The block sits between per-function SMI endpoints and a single upstream SMI port.

---
 rtl/smi_frame_arbiter_x2_pkg.sv | 16 +
 rtl/smi_frame_arbiter_x2_if.sv | 16 +
 rtl/smi_frame_out_buffer.sv | 65 ++++++
 rtl/smi_frame_arbiter_x2.sv | 119 +++++++++++
 tb/tb_smi_frame_arbiter_x2.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/smi_frame_arbiter_x2_pkg.sv
// Shared types and constants for the two-input SMI frame arbiter.
package smi_frame_arbiter_x2_pkg;

  localparam int unsigned DefFlitWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFwdA,
    StFwdB
  } arbState_t;

  function automatic logic eofcLast(input logic [7:0] eofc);
    return eofc != 8'd0;
  endfunction

endpackage

// File: rtl/smi_frame_arbiter_x2_if.sv
// One SMI flit stream: valid (ready), end-of-frame control, data and backpressure (stop).
interface smi_frame_arbiter_x2_if
  import smi_frame_arbiter_x2_pkg::*;
#(
  parameter int unsigned FlitWidth = DefFlitWidth
) ();

  logic                   ready;
  logic [7:0]             eofc;
  logic [FlitWidth*8-1:0] data;
  logic                   stop;

  modport master (output ready, output eofc, output data, input stop);
  modport slave  (input ready, input eofc, input data, output stop);

endinterface

// File: rtl/smi_frame_out_buffer.sv
// Two-entry SMI self-link double buffer; stop is registered so the upstream path stays short.
module smi_frame_out_buffer #(
  parameter int unsigned Width = 136
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             inValid,
  input  logic [Width-1:0] inData,
  output logic             inStop,
  output logic             outValid,
  output logic [Width-1:0] outData,
  input  logic             outStop
);

  logic             mainValidQ, mainValidD;
  logic             skidValidQ, skidValidD;
  logic [Width-1:0] mainDataQ, mainDataD;
  logic [Width-1:0] skidDataQ, skidDataD;
  logic             push, pop;

  assign inStop   = skidValidQ;
  assign push     = inValid && !skidValidQ;
  assign pop      = mainValidQ && !outStop;
  assign outValid = mainValidQ;
  assign outData  = mainDataQ;

  always_comb begin
    mainValidD = mainValidQ;
    mainDataD  = mainDataQ;
    skidValidD = skidValidQ;
    skidDataD  = skidDataQ;
    if (skidValidQ) begin
      // Skid full means no push this cycle; drain it into the output slot.
      if (pop) begin
        mainDataD  = skidDataQ;
        skidValidD = 1'b0;
      end
    end else if (push) begin
      if (!mainValidQ || pop) begin
        mainValidD = 1'b1;
        mainDataD  = inData;
      end else begin
        skidValidD = 1'b1;
        skidDataD  = inData;
      end
    end else if (pop) begin
      mainValidD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mainValidQ <= 1'b0;
      skidValidQ <= 1'b0;
      mainDataQ  <= '0;
      skidDataQ  <= '0;
    end else begin
      mainValidQ <= mainValidD;
      skidValidQ <= skidValidD;
      mainDataQ  <= mainDataD;
      skidDataQ  <= skidDataD;
    end
  end

endmodule

// File: rtl/smi_frame_arbiter_x2.sv
// Merges two SMI frame streams onto one output with frame-atomic round-robin arbitration.
module smi_frame_arbiter_x2
  import smi_frame_arbiter_x2_pkg::*;
#(
  parameter int unsigned FlitWidth = DefFlitWidth,
  parameter int unsigned EofcMask  = 2 * FlitWidth - 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  smi_frame_arbiter_x2_if.slave  smiInA,
  smi_frame_arbiter_x2_if.slave  smiInB,
  smi_frame_arbiter_x2_if.master smiOut
);

  localparam int unsigned DataW    = FlitWidth * 8;
  localparam int unsigned BufW     = DataW + 8;
  localparam logic [7:0]  MaskByte = 8'(EofcMask);

  // Index 0 is input A, index 1 is input B.
  logic [1:0]       inReady, fullQ, firstQ, grant, fwd, stop, head;
  logic [7:0]       inEofc [2];
  logic [DataW-1:0] inData [2];
  logic [7:0]       eofcQ [2];
  logic [DataW-1:0] dataQ [2];

  arbState_t stateQ, stateD;
  logic      lastGrantQ, lastGrantD;  // 0: A, 1: B

  logic            bufStop, bufOutValid;
  logic [BufW-1:0] bufInData, bufOutData;

  assign inReady   = {smiInB.ready, smiInA.ready};
  assign inEofc[0] = smiInA.eofc;
  assign inEofc[1] = smiInB.eofc;
  assign inData[0] = smiInA.data;
  assign inData[1] = smiInB.data;

  assign grant = {stateQ == StFwdB, stateQ == StFwdA};
  assign fwd   = grant & fullQ & {2{~bufStop}};
  assign stop  = fullQ & (~grant | {2{bufStop}});
  assign head  = fullQ & firstQ;

  assign smiInA.stop = stop[0];
  assign smiInB.stop = stop[1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fullQ  <= '0;
      firstQ <= '1;
      for (int i = 0; i < 2; i++) begin
        eofcQ[i] <= '0;
        dataQ[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        // Not stopped implies the register is empty or being forwarded now.
        if (inReady[i] && !stop[i]) begin
          fullQ[i] <= 1'b1;
          eofcQ[i] <= inEofc[i] & MaskByte;
          dataQ[i] <= inData[i];
        end else if (fwd[i]) begin
          fullQ[i] <= 1'b0;
        end
        if (fwd[i]) begin
          firstQ[i] <= eofcLast(eofcQ[i]);
        end
      end
    end
  end

  always_comb begin
    stateD     = stateQ;
    lastGrantD = lastGrantQ;
    unique case (stateQ)
      StIdle: begin
        if (head[0] && (!head[1] || lastGrantQ)) begin
          stateD     = StFwdA;
          lastGrantD = 1'b0;
        end else if (head[1]) begin
          stateD     = StFwdB;
          lastGrantD = 1'b1;
        end
      end
      StFwdA: if (fwd[0] && eofcLast(eofcQ[0])) stateD = StIdle;
      StFwdB: if (fwd[1] && eofcLast(eofcQ[1])) stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stateQ     <= StIdle;
      lastGrantQ <= 1'b1;
    end else begin
      stateQ     <= stateD;
      lastGrantQ <= lastGrantD;
    end
  end

  assign bufInData = grant[1] ? {eofcQ[1], dataQ[1]} : {eofcQ[0], dataQ[0]};

  smi_frame_out_buffer #(
    .Width(BufW)
  ) u_outBuf (
    .clk     (clk),
    .nrst    (nrst),
    .inValid (|fwd),
    .inData  (bufInData),
    .inStop  (bufStop),
    .outValid(bufOutValid),
    .outData (bufOutData),
    .outStop (smiOut.stop)
  );

  assign smiOut.ready = bufOutValid;
  assign smiOut.eofc  = bufOutData[DataW +: 8];
  assign smiOut.data  = bufOutData[DataW-1:0];

endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// Directed bench for smi_frame_arbiter_x2: cycle table plus multi-cycle sequences.
module tb_smi_frame_arbiter_x2;

  localparam int unsigned FW = 16;
  localparam int unsigned DW = FW * 8;

  localparam logic [DW-1:0] DA0 = {16{8'hA0}};
  localparam logic [DW-1:0] DA1 = {16{8'hA1}};
  localparam logic [DW-1:0] DB0 = {16{8'hB0}};
  localparam logic [DW-1:0] DB1 = {16{8'hB1}};

  logic clk = 1'b0;
  logic nrst;
  int   cyc = 0;
  int   passCnt = 0;
  int   totalCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) inA ();
  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) inB ();
  smi_frame_arbiter_x2_if #(.FlitWidth(FW)) out ();

  smi_frame_arbiter_x2 #(
    .FlitWidth(FW)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .smiInA(inA),
    .smiInB(inB),
    .smiOut(out)
  );

  typedef struct {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
    int            cyc;
  } flit_t;

  flit_t mon[$];
  bit    sawStopDuringBp = 1'b0;

  always @(negedge clk) begin
    if (nrst) begin
      if (out.ready && !out.stop) mon.push_back('{out.eofc, out.data, cyc});
      if (out.stop && inA.stop) sawStopDuringBp = 1'b1;
    end
  end

  typedef struct {
    logic          aRdy;
    logic [7:0]    aEofc;
    logic [DW-1:0] aData;
    logic          bRdy;
    logic [7:0]    bEofc;
    logic [DW-1:0] bData;
    logic          oStop;
    logic          expRdy;
    logic [7:0]    expEofc;
    logic [DW-1:0] expData;
    logic          expAStop;
    logic          expBStop;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic setIn(input bit isB, input logic rdy, input logic [7:0] e,
                       input logic [DW-1:0] d);
    if (isB) begin
      inB.ready = rdy;
      inB.eofc  = e;
      inB.data  = d;
    end else begin
      inA.ready = rdy;
      inA.eofc  = e;
      inA.data  = d;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the flit transferred.
  task automatic drive(input bit isB, input logic [7:0] e, input logic [DW-1:0] d);
    logic st;
    int   n;
    setIn(isB, 1'b1, e, d);
    n = 0;
    do begin
      @(negedge clk);
      st = isB ? inB.stop : inA.stop;
      @(posedge clk);
      n++;
    end while (st && n < 100);
    check($sformatf("%s accept %0h", isB ? "B" : "A", d[7:0]), DW'(st), '0);
    #1 setIn(isB, 1'b0, 8'h00, '0);
  endtask

  vec_t vecs[9];
  int   accCyc;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    setIn(1'b0, 1'b0, 8'h00, '0);
    setIn(1'b1, 1'b0, 8'h00, '0);
    out.stop = 1'b0;
    #1;
    check("reset outReady", DW'(out.ready), '0);
    check("reset outEofc", DW'(out.eofc), '0);
    check("reset outData", out.data, '0);
    check("reset aStop", DW'(inA.stop), '0);
    check("reset bStop", DW'(inB.stop), '0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous 2-flit heads after reset: A wins, one bubble, then B; A's 0xFF eofc masked.
    vecs[0] = '{1'b1, 8'h00, DA0, 1'b1, 8'h00, DB0, 1'b0, 1'b0, 8'h00, '0,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, DA1, 1'b1, 8'h08, DB1, 1'b0, 1'b0, 8'h00, '0,  1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'hFF, DA1, 1'b1, 8'h08, DB1, 1'b0, 1'b0, 8'h00, '0,  1'b0, 1'b1};
    vecs[3] = '{1'b0, 8'h00, '0,  1'b1, 8'h08, DB1, 1'b0, 1'b1, 8'h00, DA0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h00, '0,  1'b1, 8'h08, DB1, 1'b0, 1'b1, 8'h1F, DA1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h00, '0,  1'b1, 8'h08, DB1, 1'b0, 1'b0, 8'h00, '0,  1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, '0,  1'b0, 8'h00, '0,  1'b0, 1'b1, 8'h00, DB0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, '0,  1'b0, 8'h00, '0,  1'b0, 1'b1, 8'h08, DB1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, '0,  1'b0, 8'h00, '0,  1'b0, 1'b0, 8'h00, '0,  1'b0, 1'b0};

    for (int k = 0; k < 9; k++) begin
      setIn(1'b0, vecs[k].aRdy, vecs[k].aEofc, vecs[k].aData);
      setIn(1'b1, vecs[k].bRdy, vecs[k].bEofc, vecs[k].bData);
      out.stop = vecs[k].oStop;
      @(negedge clk);
      check($sformatf("vec%0d outReady", k), DW'(out.ready), DW'(vecs[k].expRdy));
      check($sformatf("vec%0d aStop", k), DW'(inA.stop), DW'(vecs[k].expAStop));
      check($sformatf("vec%0d bStop", k), DW'(inB.stop), DW'(vecs[k].expBStop));
      if (vecs[k].expRdy) begin
        check($sformatf("vec%0d outEofc", k), DW'(out.eofc), DW'(vecs[k].expEofc));
        check($sformatf("vec%0d outData", k), out.data, vecs[k].expData);
      end
      @(posedge clk);
      #1;
    end

    // Round-robin over continuous single-flit frames.
    mon.delete();
    fork
      for (int i = 0; i < 4; i++) drive(1'b0, 8'h04, DW'(32'hA0 + i));
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h04, DW'(32'hB0 + i));
    join
    repeat (8) @(posedge clk);
    #1;
    check("rr count", DW'(mon.size()), DW'(8));
    for (int i = 0; i < 8 && i < mon.size(); i++) begin
      check($sformatf("rr%0d data", i), mon[i].data,
            DW'((i % 2 == 0) ? 32'hA0 + i / 2 : 32'hB0 + i / 2));
      check($sformatf("rr%0d eofc", i), DW'(mon[i].eofc), DW'(8'h04));
      if (i > 0) check($sformatf("rr%0d gap", i), DW'(mon[i].cyc - mon[i-1].cyc), DW'(2));
    end

    // Single stream on A: latency and contents.
    mon.delete();
    drive(1'b0, 8'h00, {16{8'h11}});
    accCyc = cyc;
    drive(1'b0, 8'h00, {16{8'h22}});
    drive(1'b0, 8'h10, {16{8'h33}});
    repeat (6) @(posedge clk);
    #1;
    check("single count", DW'(mon.size()), DW'(3));
    if (mon.size() == 3) begin
      check("single latency", DW'(mon[0].cyc - accCyc), DW'(2));
      check("single d0", mon[0].data, {16{8'h11}});
      check("single d1", mon[1].data, {16{8'h22}});
      check("single d2", mon[2].data, {16{8'h33}});
      check("single e1", DW'(mon[1].eofc), '0);
      check("single e2", DW'(mon[2].eofc), DW'(8'h10));
    end

    // Output backpressure for 3 cycles mid-frame.
    mon.delete();
    sawStopDuringBp = 1'b0;
    fork
      for (int i = 0; i < 4; i++) drive(1'b0, (i == 3) ? 8'h02 : 8'h00, DW'(32'h41 + i));
      begin
        repeat (4) @(posedge clk);
        #1 out.stop = 1'b1;
        repeat (3) @(posedge clk);
        #1 out.stop = 1'b0;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("bp count", DW'(mon.size()), DW'(4));
    for (int i = 0; i < 4 && i < mon.size(); i++) begin
      check($sformatf("bp%0d data", i), mon[i].data, DW'(32'h41 + i));
    end
    if (mon.size() == 4) check("bp last eofc", DW'(mon[3].eofc), DW'(8'h02));
    check("bp stop propagates", DW'(sawStopDuringBp), DW'(1));

    // Reset in the middle of an A frame; the next B frame must pass complete.
    drive(1'b0, 8'h00, DW'(32'h51));
    drive(1'b0, 8'h00, DW'(32'h52));
    check("pre-reset outReady", DW'(out.ready), DW'(1));
    #1 nrst = 1'b0;
    #1;
    check("midreset outReady", DW'(out.ready), '0);
    check("midreset outEofc", DW'(out.eofc), '0);
    check("midreset outData", out.data, '0);
    check("midreset aStop", DW'(inA.stop), '0);
    check("midreset bStop", DW'(inB.stop), '0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    mon.delete();
    @(posedge clk);
    #1;
    drive(1'b1, 8'h00, DW'(32'hC1));
    drive(1'b1, 8'h01, DW'(32'hC2));
    repeat (8) @(posedge clk);
    #1;
    check("postreset count", DW'(mon.size()), DW'(2));
    if (mon.size() == 2) begin
      check("postreset d0", mon[0].data, DW'(32'hC1));
      check("postreset d1", mon[1].data, DW'(32'hC2));
      check("postreset e1", DW'(mon[1].eofc), DW'(8'h01));
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
